// File: rtl/inpass_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : inpass_sync_filter
// Purpose  : Parametrised input-pass block for IO/RAM_IO tiles. Each of the
//            NUM_CH external pad inputs is forwarded to the switch matrix
//            through a per-channel source selected by 2 frame-config bits:
//              00 combinational pass-through
//              01 single register
//              10 2-flop synchroniser
//              11 2-flop synchroniser followed by a glitch filter that needs
//                 FILTER_LEN consecutive differing samples before it changes
//            A change-event pulse E[k] flags every change of O[k] in the
//            registered modes.
// Ports    : UserCLK    - user clock (shared)
//            resetn     - synchronous active-low reset
//            I          - external pad inputs          [NUM_CH]
//            O          - selected data to switch matrix [NUM_CH]
//            E          - one-cycle change event        [NUM_CH]
//            ConfigBits - mode of channel k at [2k+1:2k] [NoConfigBits]
// Revision : 1.0 - initial release
// ============================================================================
module inpass_sync_filter #(
  parameter int NUM_CH       = 4,
  parameter int FILTER_LEN   = 4,
  parameter int NoConfigBits = 2 * NUM_CH
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,
  output logic [NUM_CH-1:0]       E,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  // One spare bit keeps FILTER_LEN=1 (clog2 = 0) at a legal width.
  localparam int                CNT_W   = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FILTER_LEN - 1);

  localparam logic [1:0] MODE_COMB = 2'b00;
  localparam logic [1:0] MODE_REG  = 2'b01;
  localparam logic [1:0] MODE_SYNC = 2'b10;
  localparam logic [1:0] MODE_FILT = 2'b11;

  logic [NUM_CH-1:0] w_o;
  logic [NUM_CH-1:0] w_e;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic             q1_q;
      logic             q2_q;
      logic             d_q;
      logic             d_d;
      logic             p_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic [1:0]       w_mode;
      logic             w_sel;

      assign w_mode = ConfigBits[2*k +: 2];

      // Glitch filter: counts consecutive cycles the synchronised value
      // disagrees with the filtered value; any agreement restarts the count.
      always_comb begin
        d_d   = d_q;
        cnt_d = cnt_q;
        if (q2_q == d_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          d_d   = q2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Mode only picks the source; every flop keeps running regardless,
      // so a runtime mode change switches O at once without losing state.
      always_comb begin
        w_sel = I[k];
        case (w_mode)
          MODE_COMB: w_sel = I[k];
          MODE_REG:  w_sel = q1_q;
          MODE_SYNC: w_sel = q2_q;
          MODE_FILT: w_sel = d_q;
          default:   w_sel = I[k];
        endcase
      end

      always_ff @(posedge UserCLK) begin
        if (!resetn) begin
          q1_q  <= 1'b0;
          q2_q  <= 1'b0;
          d_q   <= 1'b0;
          cnt_q <= '0;
          p_q   <= 1'b0;
        end else begin
          q1_q  <= I[k];
          q2_q  <= q1_q;
          d_q   <= d_d;
          cnt_q <= cnt_d;
          p_q   <= w_sel;
        end
      end

      assign w_o[k] = w_sel;
      // Suppressed in combinational mode, where O can toggle between edges.
      assign w_e[k] = (w_mode != MODE_COMB) & (w_sel ^ p_q);
    end
  endgenerate

  assign O = w_o;
  assign E = w_e;

endmodule
`default_nettype wire
